// File: rtl/binary_to_gray_counter.sv
// N-bit up/down binary counter with a registered Gray-code image, wrap pulse and
// terminal-count flag. Every output is a flop, so no input reaches an output combinationally.
module binary_to_gray_counter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dn,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         wrap,
    output logic         at_term
);

    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
    localparam logic [N-1:0] ALL_ZERO = {N{1'b0}};
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] bin_q;
    logic [N-1:0] bin_d;
    logic [N-1:0] gray_q;
    logic [N-1:0] gray_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         at_term_q;
    logic         at_term_d;

    // Load beats count; hold leaves bin_d at the current value.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (dn) begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == ALL_ZERO);
            end else begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end
        end
        at_term_d = dn ? (bin_d == ALL_ZERO) : (bin_d == ALL_ONES);
    end

    // Gray is encoded from the next binary value so it never lags bin_out.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_gray
            assign gray_d[gi] = bin_d[gi] ^ bin_d[gi+1];
        end
    endgenerate
    assign gray_d[N-1] = bin_d[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= ALL_ZERO;
            gray_q    <= ALL_ZERO;
            wrap_q    <= 1'b0;
            at_term_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrap_q    <= wrap_d;
            at_term_q <= at_term_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign at_term  = at_term_q;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Bench for binary_to_gray_counter: directed N=4 sequences with literal expectations,
// plus 10k random cycles on N=16, all tracked by an arithmetic reference model.
module tb_binary_to_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance (directed)
    logic       s_rst = 1'b1, s_en = 1'b0, s_dn = 1'b0, s_load = 1'b0;
    logic [3:0] s_lb = 4'd0;
    logic [3:0] s_bin, s_gray;
    logic       s_wrap, s_term;

    // N=16 instance (random)
    logic        r_rst = 1'b1, r_en = 1'b0, r_dn = 1'b0, r_load = 1'b0;
    logic [15:0] r_lb = 16'd0;
    logic [15:0] r_bin, r_gray;
    logic        r_wrap, r_term;

    binary_to_gray_counter #(.N(4)) dut4 (
        .clk(clk), .rst(s_rst), .en(s_en), .dn(s_dn), .load(s_load), .load_bin(s_lb),
        .bin_out(s_bin), .gray_out(s_gray), .wrap(s_wrap), .at_term(s_term)
    );

    binary_to_gray_counter #(.N(16)) dut16 (
        .clk(clk), .rst(r_rst), .en(r_en), .dn(r_dn), .load(r_load), .load_bin(r_lb),
        .bin_out(r_bin), .gray_out(r_gray), .wrap(r_wrap), .at_term(r_term)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: count as an integer modulo 2^w; returns {at_term, wrap, count}.
    function automatic logic [17:0] model_step(input int cur, input logic rst, input logic load,
                                               input int lb, input logic en, input logic dn,
                                               input int w);
        int m;
        int nxt;
        bit wr;
        bit tm;
        m   = 1 << w;
        nxt = cur;
        wr  = 1'b0;
        if (rst) begin
            return 18'd0;
        end
        if (load) begin
            nxt = lb;
        end else if (en) begin
            if (dn) begin
                nxt = (cur + m - 1) % m;
                wr  = (cur == 0);
            end else begin
                nxt = (cur + 1) % m;
                wr  = (cur == m - 1);
            end
        end
        tm = dn ? (nxt == 0) : (nxt == m - 1);
        return {tm, wr, 16'(nxt)};
    endfunction

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Gray decode the long way: bit i of binary is the XOR of gray bits i and above.
    function automatic int from_gray(input int g, input int w);
        int b;
        int acc;
        b   = 0;
        acc = 0;
        for (int i = w - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            b   = b | (acc << i);
        end
        return b;
    endfunction

    int m4_bin = 0, m16_bin = 0;
    bit m4_wrap, m4_term, m4_step, m16_wrap, m16_term, m16_step;

    always @(posedge clk) begin
        logic [17:0] r4;
        logic [17:0] r16;
        r4       = model_step(m4_bin, s_rst, s_load, int'(s_lb), s_en, s_dn, 4);
        m4_step  = !s_rst && !s_load && s_en;
        m4_bin   = int'(r4[15:0]);
        m4_wrap  = r4[16];
        m4_term  = r4[17];
        r16      = model_step(m16_bin, r_rst, r_load, int'(r_lb), r_en, r_dn, 16);
        m16_step = !r_rst && !r_load && r_en;
        m16_bin  = int'(r16[15:0]);
        m16_wrap = r16[16];
        m16_term = r16[17];
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic [3:0]  prev_gray4;
    logic [15:0] prev_gray16;
    always @(negedge clk) begin
        if (started) begin
            cmp("bin4",  32'(s_bin),  32'(m4_bin));
            cmp("gray4", 32'(s_gray), 32'(to_gray(m4_bin)));
            cmp("wrap4", 32'(s_wrap), 32'(m4_wrap));
            cmp("term4", 32'(s_term), 32'(m4_term));
            cmp("bin16",  32'(r_bin),  32'(m16_bin));
            cmp("gray16", 32'(r_gray), 32'(to_gray(m16_bin)));
            cmp("wrap16", 32'(r_wrap), 32'(m16_wrap));
            cmp("term16", 32'(r_term), 32'(m16_term));
            cmp("decode16", 32'(from_gray(int'(r_gray), 16)), 32'(m16_bin));
            if (m4_step)
                cmp("onebit4", 32'($countones(s_gray ^ prev_gray4)), 32'd1);
            if (m16_step)
                cmp("onebit16", 32'($countones(r_gray ^ prev_gray16)), 32'd1);
        end
        prev_gray4  = s_gray;
        prev_gray16 = r_gray;
    end

    logic [3:0] up_gray [16];
    logic [15:0] pick;

    initial begin
        up_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        repeat (2) @(negedge clk);
        started = 1'b1;
        cmp("rst_bin",  32'(s_bin),  32'd0);
        cmp("rst_gray", 32'(s_gray), 32'd0);
        cmp("rst_wrap", 32'(s_wrap), 32'd0);
        cmp("rst_term", 32'(s_term), 32'd0);

        // Full up-count cycle
        s_rst = 1'b0; s_en = 1'b1; s_dn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            $display("up step %0d: bin=%0h gray=%0h wrap=%0b term=%0b", i, s_bin, s_gray, s_wrap, s_term);
            cmp("up_gray", 32'(s_gray), 32'(up_gray[i]));
            cmp("up_bin",  32'(s_bin),  32'((i + 1) % 16));
            cmp("up_wrap", 32'(s_wrap), 32'(i == 15));
            cmp("up_term", 32'(s_term), 32'(i == 14));
        end

        // Down from zero wraps to 15
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0; s_dn = 1'b1;
        @(negedge clk);
        cmp("dn_bin",  32'(s_bin),  32'd15);
        cmp("dn_gray", 32'(s_gray), 32'h8);
        cmp("dn_wrap", 32'(s_wrap), 32'd1);
        @(negedge clk);
        cmp("dn2_bin",  32'(s_bin),  32'd14);
        cmp("dn2_gray", 32'(s_gray), 32'h9);
        cmp("dn2_wrap", 32'(s_wrap), 32'd0);

        // Load wins over count
        s_load = 1'b1; s_lb = 4'd5; s_dn = 1'b0;
        @(negedge clk);
        cmp("ld_bin",  32'(s_bin),  32'd5);
        cmp("ld_gray", 32'(s_gray), 32'h7);
        cmp("ld_wrap", 32'(s_wrap), 32'd0);
        s_load = 1'b0;
        @(negedge clk);
        cmp("ld_next_bin",  32'(s_bin),  32'd6);
        cmp("ld_next_gray", 32'(s_gray), 32'h5);

        // Reset overrides load and en mid-count
        repeat (3) @(negedge clk);
        cmp("pre_rst_bin", 32'(s_bin), 32'd9);
        s_rst = 1'b1; s_load = 1'b1; s_lb = 4'd3;
        @(negedge clk);
        cmp("mid_rst_bin",  32'(s_bin),  32'd0);
        cmp("mid_rst_gray", 32'(s_gray), 32'd0);
        cmp("mid_rst_wrap", 32'(s_wrap), 32'd0);
        cmp("mid_rst_term", 32'(s_term), 32'd0);

        // Hold at 12
        s_rst = 1'b0; s_load = 1'b1; s_lb = 4'd12; s_en = 1'b0;
        @(negedge clk);
        s_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("hold_bin",  32'(s_bin),  32'd12);
            cmp("hold_gray", 32'(s_gray), 32'hA);
            cmp("hold_wrap", 32'(s_wrap), 32'd0);
        end
        $display("directed phase done: checks=%0d errors=%0d", checks, errors);

        // Random phase on N=16, biased toward loads near the wrap points
        r_rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            r_rst  = ($urandom_range(0, 199) == 0);
            r_load = ($urandom_range(0, 15) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_dn   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: pick = 16'h0000;
                1: pick = 16'hFFFF;
                2: pick = 16'hFFFE;
                3: pick = 16'h0001;
                default: pick = 16'($urandom);
            endcase
            r_lb = pick;
            @(negedge clk);
        end
        r_rst = 1'b0; r_load = 1'b0; r_en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_to_gray_counter.md
Name: binary_to_gray_counter

Overview:
- N-bit up/down binary counter that produces a registered Gray-code image of its count every cycle.
- This is the encode direction of the Gray datapath; its Gray output feeds the existing gray_to_binary decoder.
- Intended as a pointer generator for clock-domain-crossing FIFOs and as a stimulus source for Gray decoders.
- Binary and Gray outputs always describe the same count in the same cycle.

Parameters:
- N, 16, counter and code width in bits (N >= 2)

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge only
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per cycle while high
- dn  input  1  direction: 0 = increment, 1 = decrement; sampled only when en=1
- load  input  1  synchronous load strobe
- load_bin  input  N  binary value loaded when load=1
- bin_out  output  N  registered binary count
- gray_out  output  N  registered Gray code of bin_out: bin_out ^ (bin_out >> 1)
- wrap  output  1  one-cycle pulse marking a wrap-around step
- at_term  output  1  registered flag: count is at the terminal value for the current direction

Behaviour:
- One clock domain. Reset is synchronous and active-high. No combinational path from any input to any output.
- Reset (rst=1 at a rising edge):
  - bin_out=0, gray_out=0, wrap=0, at_term=0.
  - rst overrides load and en.
  - Reset asserted mid-count takes effect at the next edge; no partial update.
- Priority at each edge: rst > load > en > hold.
- Load (load=1, rst=0):
  - bin_out=load_bin; gray_out=load_bin ^ (load_bin>>1); wrap=0.
  - en and dn are ignored in that cycle.
- Count (en=1, load=0, rst=0):
  - next = bin_out+1 when dn=0, bin_out-1 when dn=1, modulo 2^N.
  - bin_out=next; gray_out=next ^ (next>>1).
- Hold (en=0, load=0, rst=0): bin_out and gray_out keep their values; wrap=0.
- Latency:
  - A command sampled at edge k is visible on the outputs immediately after edge k (1-cycle register latency).
  - gray_out is computed from the next binary value, not from the current gray_out, so it never lags bin_out.
- wrap:
  - Goes high for exactly the cycle after an edge that steps up from 2^N-1 to 0, or down from 0 to 2^N-1.
  - Loads and reset never assert wrap.
- at_term:
  - Registered equal to (next==2^N-1 and dn=0) or (next==0 and dn=1), where next is the value just registered.
  - For this flag, dn is taken as sampled at that edge, including hold and load cycles.
  - at_term is 0 out of reset.
- Gray property:
  - Every count step changes exactly one bit of gray_out, including across wrap.
  - A load may change any number of bits.
- Direction reversal on consecutive cycles is legal; each step is independent.

Test Plan:
- Reset, then en=1, dn=0 for 16 cycles, N=4 -> gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. wrap pulses only on the 15->0 step. at_term=1 while bin_out=15.
- After reset, en=1, dn=1, N=4 -> bin_out 15, gray_out 8, wrap=1 for one cycle; next step gives bin_out 14, gray_out 9, wrap=0.
- load=1, load_bin=5 with en=1 in the same cycle -> bin_out=5, gray_out=7, wrap=0; count was not applied. Next en cycle up -> bin_out=6, gray_out=5.
- Count to bin_out=9, then assert rst with en=1 and load=1 -> next cycle bin_out=0, gray_out=0, wrap=0, at_term=0.
- en=0 for 5 cycles at bin_out=12 -> bin_out stays 12, gray_out stays A, wrap stays 0.
- Random en/dn/load for 10k cycles, N=16:
  - gray_out always equals bin_out ^ (bin_out>>1).
  - Exactly one bit changes per step.
  - Passing gray_out through gray_to_binary returns bin_out.
